// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, issues one-cycle-latency memory reads,
// buffers returned words in a 2-entry queue and handles redirects and HALT.
module instruction_fetch #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [7:0]  HALT_OPCODE = 8'h0F
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    output logic        halted_o
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [1:0]        count_q;
    logic [31:0]       head_inst_q;
    logic [ADDR_W-1:0] head_pc_q;
    logic [31:0]       tail_inst_q;
    logic [ADDR_W-1:0] tail_pc_q;

    logic       pop;
    logic       ret;
    logic       halt_det;
    logic       issue;
    logic [2:0] occupancy;
    logic [1:0] count_d;
    logic       head_from_tail;
    logic       head_from_mem;
    logic       tail_from_mem;

    // Only the low ADDR_W bits of the redirect target address memory.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc_i[31:ADDR_W];

    assign mem_addr_o  = {{(32-ADDR_W){1'b0}}, pc_q};
    assign out_valid_o = (count_q != 2'd0);
    assign out_inst_o  = head_inst_q;
    assign out_pc_o    = {{(32-ADDR_W){1'b0}}, head_pc_q};
    assign halted_o    = (state_q == ST_HALT);

    always_comb begin
        pop       = out_valid_o & out_ready_i;
        ret       = inflight_q & ~redirect_i;
        halt_det  = ret & (mem_inst_i[31:24] == HALT_OPCODE);
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        // Words already queued or in flight must fit once this cycle's pop is taken.
        issue     = (state_q == ST_FETCH) & ~redirect_i & ~halt_det
                  & (occupancy < (3'd2 + {2'b00, pop}));

        count_d = count_q;
        if (pop && !ret) begin
            count_d = count_q - 2'd1;
        end else if (!pop && ret) begin
            count_d = count_q + 2'd1;
        end

        head_from_tail = pop & (count_q == 2'd2);
        head_from_mem  = ret & ((count_q == 2'd0) | ((count_q == 2'd1) & pop));
        tail_from_mem  = ret & (((count_q == 2'd1) & ~pop) | ((count_q == 2'd2) & pop));
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC[ADDR_W-1:0];
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            head_inst_q   <= '0;
            head_pc_q     <= '0;
            tail_inst_q   <= '0;
            tail_pc_q     <= '0;
        end else if (redirect_i) begin
            state_q    <= ST_FETCH;
            pc_q       <= redirect_pc_i[ADDR_W-1:0];
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q          <= pc_q + 1'b1;
                inflight_pc_q <= pc_q;
            end
            if (halt_det) begin
                state_q <= ST_HALT;
            end

            count_q <= count_d;
            if (head_from_tail) begin
                head_inst_q <= tail_inst_q;
                head_pc_q   <= tail_pc_q;
            end else if (head_from_mem) begin
                head_inst_q <= mem_inst_i;
                head_pc_q   <= inflight_pc_q;
            end
            if (tail_from_mem) begin
                tail_inst_q <= mem_inst_i;
                tail_pc_q   <= inflight_pc_q;
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch unit that initiates every access to the synchronous instruction memory. It owns the program counter, drives the memory word address, and tracks the one-cycle read latency. It buffers returned words in a 2-entry queue and hands them to decode over a valid/ready handshake. It also handles control-flow redirects and stops fetching once it sees a HALT opcode.

## Interface
- ADDR_W, 10: word-address width of instruction memory (1024 words).
- RESET_PC, 0: PC loaded on reset.
- HALT_OPCODE, 8'h0F: value of Inst[31:24] that stops fetch.

- CLK  input  1  clock, rising-edge.
- RESETN  input  1  reset, asynchronous, active-low.
- MEM_ADDR  output  32  word address to instruction memory, {zeros, pc[ADDR_W-1:0]}.
- MEM_INST  input  32  memory read data; holds Mem[address sampled at previous edge].
- REDIRECT  input  1  single-cycle request to restart fetch at REDIRECT_PC.
- REDIRECT_PC  input  32  redirect target; only bits [ADDR_W-1:0] used.
- OUT_VALID  output  1  OUT_INST/OUT_PC hold a valid instruction.
- OUT_READY  input  1  decode accepts the head this cycle.
- OUT_INST  output  32  fetched instruction.
- OUT_PC  output  32  word address of OUT_INST, zero-extended.
- HALTED  output  1  fetch stopped on HALT_OPCODE.

## Operation
- State: pc (ADDR_W bits), inflight_q, inflight_pc_q, 2-entry FIFO {inst, pc} with count 0..2, and fsm {FETCH, HALT}.
- MEM_ADDR is combinational from pc. Memory reads every cycle, so a returned word is meaningful only when inflight_q=1.
- pop = OUT_VALID & OUT_READY. OUT_VALID = (count != 0). OUT_INST/OUT_PC come from the FIFO head.
- ret = inflight_q & !REDIRECT. When ret=1, MEM_INST/inflight_pc_q are pushed to the FIFO.
- halt_det = ret & (MEM_INST[31:24] == HALT_OPCODE).
- issue = (fsm==FETCH) & !REDIRECT & !halt_det & (count + inflight_q - pop < 2).
- On issue: pc <= pc+1 (wraps 2^ADDR_W-1 -> 0), inflight_q <= 1, inflight_pc_q <= pc. Otherwise inflight_q <= 0.
- halt_det: the HALT word is still pushed, then fsm <= HALT. No further issue, and pc stays at halt address +1.
- REDIRECT has priority over everything:
  - A pop in the same cycle completes normally.
  - All remaining FIFO entries are flushed (count <= 0) and the in-flight word is squashed.
  - pc <= REDIRECT_PC[ADDR_W-1:0] and fsm <= FETCH, including when in HALT.
  - No issue in the redirect cycle.
- HALTED = (fsm==HALT).
- FIFO never overflows; the issue condition guarantees count + inflight never exceeds 2.

## Timing
- Reset values (asynchronous):
  - pc=RESET_PC, MEM_ADDR=RESET_PC.
  - inflight_q=0, count=0, OUT_VALID=0, OUT_INST=0, OUT_PC=0.
  - fsm=FETCH, HALTED=0.
- Edge E1 is the first edge with RESETN high. It issues RESET_PC.
- After E2, OUT_VALID=1 with the word at RESET_PC. Issue-to-output latency is 2 edges.
- Throughput is 1 instruction/cycle with OUT_READY held high.
- OUT_READY low: head and OUT_VALID hold stable. At most 2 words are buffered, with no drop and no duplicate. Fetch resumes the cycle after space frees.
- Redirect asserted at edge En: the first new OUT_VALID appears after En+2, i.e. 2-cycle bubble.
- HALT word is output normally. HALTED rises the edge after the HALT word returns from memory, before or coincident with its FIFO visibility. No instruction after HALT is ever output.
- RESETN low mid-operation clears all state immediately, including OUT_VALID. In-flight data is discarded.

## Test plan
- Straight line: Mem[k]=32'h1000_0000+k, OUT_READY=1 after reset.
  - OUT_VALID rises after E2.
  - OUT_PC 0,1,2,... on consecutive cycles with OUT_INST matching.
- Halt: Mem[9]=32'h0F00_0000.
  - Outputs PC 0..9 only, with PC 9 carrying 32'h0F00_0000.
  - HALTED=1 and pc frozen at 10.
  - OUT_VALID stays 0 after PC 9 is popped.
- Backpressure: drop OUT_READY for 5 cycles while PC 3 is head.
  - OUT_PC=3 held throughout.
  - After release: 3,4,5... with no gaps or repeats.
- Redirect: REDIRECT=1, REDIRECT_PC=3 while PC 8 is head and accepted.
  - PC 8 is consumed; PC 9 is discarded.
  - Next output is PC 3, two cycles later.
  - Repeat from HALT: HALTED drops and fetch restarts at the target.
- Wrap: REDIRECT_PC=1023 with ADDR_W=10.
  - Outputs PC 1023 then PC 0.
  - MEM_ADDR upper 22 bits are always 0.
- Reset mid-stream: pulse RESETN low for 1 cycle while count=2.
  - OUT_VALID=0 immediately.
  - Sequence restarts at PC 0 with 2-edge latency.
